// File: rtl/algo_16m8d_m70_cpu_regs.sv
// -----------------------------------------------------------------------------
// algo_16m8d_m70_cpu_regs
// CPU-port register responder for the 16m8d_m70 memory algorithm.
//
// It holds the core configuration (bp_thr, bp_hys, ena_rand) and collects
// map-access ECC statistics. These are a saturating single-bit count, a
// saturating double-bit count, and the physical address of the first
// double-bit error, which stays fixed until software clears it.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   ready             live core ready status (readable at STATUS)
//   ma_vld/serr/derr  per-port map-access valid and ECC error flags
//   ma_padr           per-port physical address, BITVROW+2 bits per port
//   grpmt             live per-bank group-empty status (readable at GRPMT)
//   cp_read/cp_write  CPU strobes; cp_adr word address, cp_din write data
//   cp_vld/cp_dout    read response, CP_DELAY cycles after cp_read
//   bp_thr/bp_hys     backpressure threshold / hysteresis to the core
//   ena_rand          randomisation enable to the core
// -----------------------------------------------------------------------------
module algo_16m8d_m70_cpu_regs #(
    parameter int NUMMAPT    = 16,
    parameter int NUMVBNK    = 8,
    parameter int BITVROW    = 11,
    parameter int BITCPAD    = 10,
    parameter int CPUWDTH    = 54,
    parameter int CNTWDTH    = 16,
    parameter int CP_DELAY   = 1,
    parameter int BP_THR_RST = 1024,
    parameter int BP_HYS_RST = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ready,
    input  logic [NUMMAPT-1:0]            ma_vld,
    input  logic [NUMMAPT-1:0]            ma_serr,
    input  logic [NUMMAPT-1:0]            ma_derr,
    input  logic [NUMMAPT*(BITVROW+2)-1:0] ma_padr,
    input  logic [NUMVBNK-1:0]            grpmt,
    input  logic                          cp_read,
    input  logic                          cp_write,
    input  logic [BITCPAD-1:0]            cp_adr,
    input  logic [CPUWDTH-1:0]            cp_din,
    output logic                          cp_vld,
    output logic [CPUWDTH-1:0]            cp_dout,
    output logic [BITVROW:0]              bp_thr,
    output logic [BITVROW:0]              bp_hys,
    output logic                          ena_rand
);

    localparam int PADW = BITVROW + 2;
    localparam int POPW = $clog2(NUMMAPT + 1);

    localparam logic [BITCPAD-1:0] ADR_CTRL  = BITCPAD'(4'h0);
    localparam logic [BITCPAD-1:0] ADR_THR   = BITCPAD'(4'h1);
    localparam logic [BITCPAD-1:0] ADR_HYS   = BITCPAD'(4'h2);
    localparam logic [BITCPAD-1:0] ADR_SERR  = BITCPAD'(4'h3);
    localparam logic [BITCPAD-1:0] ADR_DERR  = BITCPAD'(4'h4);
    localparam logic [BITCPAD-1:0] ADR_EADR  = BITCPAD'(4'h5);
    localparam logic [BITCPAD-1:0] ADR_GRPMT = BITCPAD'(4'h6);
    localparam logic [BITCPAD-1:0] ADR_STAT  = BITCPAD'(4'h7);

    // Number of set bits in a per-port flag vector.
    function automatic logic [POPW-1:0] popcount(input logic [NUMMAPT-1:0] v);
        logic [POPW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUMMAPT; i++) begin
            cnt = cnt + POPW'(v[i]);
        end
        return cnt;
    endfunction

    // Counter add that sticks at all-ones instead of wrapping.
    function automatic logic [CNTWDTH-1:0] sat_add(input logic [CNTWDTH-1:0] base,
                                                   input logic [POPW-1:0]    inc);
        logic [CNTWDTH:0] sum;
        sum = {1'b0, base} + (CNTWDTH+1)'(inc);
        if (sum[CNTWDTH]) begin
            return {CNTWDTH{1'b1}};
        end else begin
            return sum[CNTWDTH-1:0];
        end
    endfunction

    logic                 r_ena_rand;
    logic [BITVROW:0]     r_bp_thr;
    logic [BITVROW:0]     r_bp_hys;
    logic [CNTWDTH-1:0]   r_serr_cnt;
    logic [CNTWDTH-1:0]   r_derr_cnt;
    logic [PADW-1:0]      r_err_adr;
    logic                 r_err_adr_vld;
    logic                 r_vld_pipe [CP_DELAY];
    logic [CPUWDTH-1:0]   r_dat_pipe [CP_DELAY];

    logic [NUMMAPT-1:0]   w_serr_q;
    logic [NUMMAPT-1:0]   w_derr_q;
    logic                 w_clr_serr;
    logic                 w_clr_derr;
    logic                 w_clr_eadr;
    logic [PADW-1:0]      w_first_padr;
    logic                 w_rd_acc;
    logic [CPUWDTH-1:0]   w_rd_data;
    logic                 w_unused_din;

    // A double error on a port masks its single error.
    assign w_serr_q = ma_vld & ma_serr & ~ma_derr;
    assign w_derr_q = ma_vld & ma_derr;

    assign w_clr_serr = cp_write && (cp_adr == ADR_SERR);
    assign w_clr_derr = cp_write && (cp_adr == ADR_DERR);
    assign w_clr_eadr = cp_write && (cp_adr == ADR_EADR);

    // A read colliding with a write is dropped.
    assign w_rd_acc = cp_read && !cp_write;

    assign w_unused_din = ^cp_din[CPUWDTH-1:BITVROW+1];

    // Address slice of the lowest-index port reporting a double error.
    always_comb begin
        w_first_padr = '0;
        for (int i = NUMMAPT - 1; i >= 0; i--) begin
            if (w_derr_q[i]) begin
                w_first_padr = ma_padr[i*PADW +: PADW];
            end else begin
                w_first_padr = w_first_padr;
            end
        end
    end

    // Read data mux, sampled from current register state.
    always_comb begin
        w_rd_data = '0;
        case (cp_adr)
            ADR_CTRL:  w_rd_data = CPUWDTH'(r_ena_rand);
            ADR_THR:   w_rd_data = CPUWDTH'(r_bp_thr);
            ADR_HYS:   w_rd_data = CPUWDTH'(r_bp_hys);
            ADR_SERR:  w_rd_data = CPUWDTH'(r_serr_cnt);
            ADR_DERR:  w_rd_data = CPUWDTH'(r_derr_cnt);
            ADR_EADR:  w_rd_data = CPUWDTH'({r_err_adr_vld, r_err_adr});
            ADR_GRPMT: w_rd_data = CPUWDTH'(grpmt);
            ADR_STAT:  w_rd_data = CPUWDTH'(ready);
            default:   w_rd_data = '0;
        endcase
    end

    // Configuration registers written by the CPU.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ena_rand <= 1'b0;
            r_bp_thr   <= (BITVROW+1)'(BP_THR_RST);
            r_bp_hys   <= (BITVROW+1)'(BP_HYS_RST);
        end else if (cp_write) begin
            case (cp_adr)
                ADR_CTRL: r_ena_rand <= cp_din[0];
                ADR_THR:  r_bp_thr   <= cp_din[BITVROW:0];
                ADR_HYS:  r_bp_hys   <= cp_din[BITVROW:0];
                default:  r_ena_rand <= r_ena_rand;
            endcase
        end
    end

    // Saturating error counters; a write-clear restarts from this cycle's count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_serr_cnt <= '0;
            r_derr_cnt <= '0;
        end else begin
            r_serr_cnt <= sat_add(w_clr_serr ? '0 : r_serr_cnt, popcount(w_serr_q));
            r_derr_cnt <= sat_add(w_clr_derr ? '0 : r_derr_cnt, popcount(w_derr_q));
        end
    end

    // First double-error address capture; sticky until write-cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_adr     <= '0;
            r_err_adr_vld <= 1'b0;
        end else if ((w_clr_eadr || !r_err_adr_vld) && (|w_derr_q)) begin
            r_err_adr     <= w_first_padr;
            r_err_adr_vld <= 1'b1;
        end else if (w_clr_eadr) begin
            r_err_adr     <= '0;
            r_err_adr_vld <= 1'b0;
        end
    end

    // Read response pipeline, CP_DELAY stages; data is zero in empty stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CP_DELAY; i++) begin
                r_vld_pipe[i] <= 1'b0;
                r_dat_pipe[i] <= '0;
            end
        end else begin
            r_vld_pipe[0] <= w_rd_acc;
            r_dat_pipe[0] <= w_rd_acc ? w_rd_data : '0;
            for (int i = 1; i < CP_DELAY; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_dat_pipe[i] <= r_dat_pipe[i-1];
            end
        end
    end

    // The response is masked while rst is high so that a reset in the cycle
    // following a read suppresses its pulse.
    assign cp_vld   = r_vld_pipe[CP_DELAY-1] & ~rst;
    assign cp_dout  = r_dat_pipe[CP_DELAY-1] & {CPUWDTH{~rst}};
    assign bp_thr   = r_bp_thr;
    assign bp_hys   = r_bp_hys;
    assign ena_rand = r_ena_rand;

endmodule

// File: tb/tb_algo_16m8d_m70_cpu_regs.sv
module tb_algo_16m8d_m70_cpu_regs;

    logic         clk = 1'b0;
    logic         rst;
    logic         ready;
    logic [15:0]  ma_vld, ma_serr, ma_derr;
    logic [207:0] ma_padr;
    logic [7:0]   grpmt;
    logic         cp_read, cp_write;
    logic [9:0]   cp_adr;
    logic [53:0]  cp_din;
    logic         cp_vld;
    logic [53:0]  cp_dout;
    logic [11:0]  bp_thr, bp_hys;
    logic         ena_rand;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [11:0] m_thr, m_hys;
    logic        m_ena;
    int          m_serr, m_derr;
    logic [12:0] m_adr;
    logic        m_adr_vld;
    logic        exp_vld;
    logic [53:0] exp_dout;

    algo_16m8d_m70_cpu_regs dut (
        .clk(clk), .rst(rst), .ready(ready),
        .ma_vld(ma_vld), .ma_serr(ma_serr), .ma_derr(ma_derr), .ma_padr(ma_padr),
        .grpmt(grpmt), .cp_read(cp_read), .cp_write(cp_write), .cp_adr(cp_adr),
        .cp_din(cp_din), .cp_vld(cp_vld), .cp_dout(cp_dout),
        .bp_thr(bp_thr), .bp_hys(bp_hys), .ena_rand(ena_rand)
    );

    always #5 clk = ~clk;

    function automatic logic [53:0] model_read(input logic [9:0] a);
        case (a)
            10'h000: return 54'(m_ena);
            10'h001: return 54'(m_thr);
            10'h002: return 54'(m_hys);
            10'h003: return 54'(m_serr);
            10'h004: return 54'(m_derr);
            10'h005: return 54'({m_adr_vld, m_adr});
            10'h006: return 54'(grpmt);
            10'h007: return 54'(ready);
            default: return 54'd0;
        endcase
    endfunction

    task automatic rand_padr();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
        ma_padr = t[207:0];
    endtask

    task automatic idle();
        cp_read = 1'b0; cp_write = 1'b0;
        ma_vld = 16'h0; ma_serr = 16'h0; ma_derr = 16'h0;
    endtask

    // Advance one clock, updating the model from the inputs applied in this cycle.
    task automatic cycle();
        logic [15:0] sq, dq;
        exp_vld  = cp_read && !cp_write && !rst;
        exp_dout = exp_vld ? model_read(cp_adr) : 54'd0;
        sq = ma_vld & ma_serr & ~ma_derr;
        dq = ma_vld & ma_derr;
        if (rst) begin
            m_thr = 12'd1024; m_hys = 12'd16; m_ena = 1'b0;
            m_serr = 0; m_derr = 0; m_adr = 13'd0; m_adr_vld = 1'b0;
        end else begin
            if (cp_write && cp_adr == 10'h000) m_ena = cp_din[0];
            if (cp_write && cp_adr == 10'h001) m_thr = cp_din[11:0];
            if (cp_write && cp_adr == 10'h002) m_hys = cp_din[11:0];
            if (cp_write && cp_adr == 10'h003) m_serr = 0;
            if (cp_write && cp_adr == 10'h004) m_derr = 0;
            m_serr = m_serr + $countones(sq);
            m_derr = m_derr + $countones(dq);
            if (m_serr > 65535) m_serr = 65535;
            if (m_derr > 65535) m_derr = 65535;
            if (cp_write && cp_adr == 10'h005) begin
                m_adr_vld = 1'b0; m_adr = 13'd0;
            end
            if (!m_adr_vld && dq != 16'h0) begin
                for (int i = 15; i >= 0; i--) if (dq[i]) m_adr = ma_padr[i*13 +: 13];
                m_adr_vld = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [9:0] a);
        cp_read = 1'b1; cp_adr = a;
        cycle();
        cp_read = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] exp_rd [3];
        logic [9:0]  adrs [3];
        exp_rd[0] = 12'd1024; exp_rd[1] = 12'd16; exp_rd[2] = 12'd0;
        adrs[0] = 10'h001; adrs[1] = 10'h002; adrs[2] = 10'h000;
        rst = 1'b1; idle();
        cycle(); cycle();
        rst = 1'b0;
        checks++;
        if (cp_vld !== 1'b0 || cp_dout !== 54'd0 || bp_thr !== 12'd1024 ||
            bp_hys !== 12'd16 || ena_rand !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: vld=%b dout=%h thr=%0d hys=%0d ena=%b want 0 0 1024 16 0",
                     cp_vld, cp_dout, bp_thr, bp_hys, ena_rand);
        end
        for (int k = 0; k < 3; k++) begin
            do_read(adrs[k]);
            checks++;
            if (cp_vld !== 1'b1 || cp_dout !== 54'(exp_rd[k])) begin
                errors++;
                $display("FAIL reset_read[%0d]: vld=%b dout=%h want 1 %h", k, cp_vld, cp_dout, exp_rd[k]);
            end
            cycle();
            checks++;
            if (cp_vld !== 1'b0 || cp_dout !== 54'd0) begin
                errors++;
                $display("FAIL idle_dout[%0d]: vld=%b dout=%h want 0 0", k, cp_vld, cp_dout);
            end
        end
    endtask

    task automatic test_write();
        cp_write = 1'b1; cp_adr = 10'h001; cp_din = {22'h3FFFFF, 32'h0000_03FF};
        cycle();
        cp_write = 1'b0;
        checks++;
        if (bp_thr !== 12'h3FF) begin
            errors++;
            $display("FAIL thr_write: bp_thr=%h want 3ff", bp_thr);
        end
        do_read(10'h001);
        checks++;
        if (cp_vld !== 1'b1 || cp_dout !== 54'h3FF) begin
            errors++;
            $display("FAIL thr_readback: vld=%b dout=%h want 1 3ff", cp_vld, cp_dout);
        end
        cp_write = 1'b1; cp_adr = 10'h000; cp_din = 54'($urandom) | 54'd1;
        cycle();
        cp_write = 1'b0;
        checks++;
        if (ena_rand !== 1'b1) begin
            errors++;
            $display("FAIL ena_write: ena_rand=%b want 1", ena_rand);
        end
    endtask

    task automatic test_errors();
        logic [13:0] first;
        rand_padr();
        first = {1'b1, ma_padr[12:0]};
        ma_vld = 16'hFFFF; ma_serr = 16'h00F3; ma_derr = 16'h0003;
        cycle();
        idle();
        do_read(10'h003);
        checks++;
        if (cp_dout !== 54'd4) begin
            errors++;
            $display("FAIL serr_cnt: got %0d want 4", cp_dout);
        end
        do_read(10'h004);
        checks++;
        if (cp_dout !== 54'd2) begin
            errors++;
            $display("FAIL derr_cnt: got %0d want 2", cp_dout);
        end
        do_read(10'h005);
        checks++;
        if (cp_dout !== 54'(first)) begin
            errors++;
            $display("FAIL err_adr: got %h want %h", cp_dout, first);
        end
        rand_padr();
        ma_vld = 16'h0020; ma_derr = 16'h0020;
        cycle();
        idle();
        do_read(10'h005);
        checks++;
        if (cp_dout !== 54'(first)) begin
            errors++;
            $display("FAIL err_adr_sticky: got %h want %h", cp_dout, first);
        end
    endtask

    task automatic test_saturation();
        cp_write = 1'b1; cp_adr = 10'h003;
        cycle();
        idle();
        ma_vld = 16'hFFFF; ma_serr = 16'hFFFF;
        for (int i = 0; i < 4095; i++) cycle();
        ma_serr = 16'h3FFF;
        cycle();
        idle();
        do_read(10'h003);
        checks++;
        if (cp_dout !== 54'hFFFE) begin
            errors++;
            $display("FAIL serr_preload: got %h want fffe", cp_dout);
        end
        for (int r = 0; r < 2; r++) begin
            ma_vld = 16'hFFFF; ma_serr = 16'h0007;
            cycle();
            idle();
            do_read(10'h003);
            checks++;
            if (cp_dout !== 54'hFFFF) begin
                errors++;
                $display("FAIL serr_sat[%0d]: got %h want ffff", r, cp_dout);
            end
        end
        cp_write = 1'b1; cp_adr = 10'h003; ma_vld = 16'hFFFF; ma_serr = 16'h0003;
        cycle();
        idle();
        do_read(10'h003);
        checks++;
        if (cp_dout !== 54'd2) begin
            errors++;
            $display("FAIL serr_clr_inc: got %0d want 2", cp_dout);
        end
    endtask

    task automatic test_collision();
        cp_read = 1'b1; cp_write = 1'b1; cp_adr = 10'h002; cp_din = 54'd5;
        cycle();
        idle();
        checks++;
        if (cp_vld !== 1'b0 || bp_hys !== 12'd5) begin
            errors++;
            $display("FAIL rw_collision: vld=%b hys=%0d want 0 5", cp_vld, bp_hys);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] g [3];
        for (int k = 0; k < 3; k++) begin
            g[k] = 8'($urandom);
            grpmt = g[k];
            do_read(10'h006);
            checks++;
            if (cp_vld !== 1'b1 || cp_dout !== 54'(g[k])) begin
                errors++;
                $display("FAIL b2b[%0d]: vld=%b dout=%h want 1 %h", k, cp_vld, cp_dout, g[k]);
            end
        end
        cycle();
        checks++;
        if (cp_vld !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: vld=%b want 0", cp_vld);
        end
    endtask

    task automatic test_reset_midread();
        do_read(10'h001);
        rst = 1'b1;
        #1;
        checks++;
        if (cp_vld !== 1'b0 || cp_dout !== 54'd0) begin
            errors++;
            $display("FAIL rst_drop_now: vld=%b dout=%h want 0 0", cp_vld, cp_dout);
        end
        cycle();
        rst = 1'b0;
        cycle();
        checks++;
        if (cp_vld !== 1'b0 || bp_thr !== 12'd1024 || bp_hys !== 12'd16) begin
            errors++;
            $display("FAIL rst_drop_after: vld=%b thr=%0d hys=%0d want 0 1024 16", cp_vld, bp_thr, bp_hys);
        end
    endtask

    task automatic test_unmapped();
        do_read(10'h3FF);
        checks++;
        if (cp_vld !== 1'b1 || cp_dout !== 54'd0) begin
            errors++;
            $display("FAIL unmapped_read: vld=%b dout=%h want 1 0", cp_vld, cp_dout);
        end
        grpmt = 8'hA5;
        cp_write = 1'b1; cp_adr = 10'h006; cp_din = {22'h0, $urandom};
        cycle();
        cp_write = 1'b0;
        do_read(10'h006);
        checks++;
        if (cp_dout !== 54'hA5 || bp_thr !== 12'd1024 || bp_hys !== 12'd16 || ena_rand !== 1'b0) begin
            errors++;
            $display("FAIL grpmt_ro: dout=%h thr=%0d hys=%0d ena=%b want a5 1024 16 0",
                     cp_dout, bp_thr, bp_hys, ena_rand);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            cp_read  = ($urandom_range(0, 1) == 0);
            cp_write = ($urandom_range(0, 3) == 0);
            cp_adr   = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 7));
            cp_din   = {22'($urandom), $urandom};
            ma_vld   = 16'($urandom);
            ma_serr  = 16'($urandom);
            ma_derr  = 16'($urandom & $urandom & $urandom);
            rand_padr();
            grpmt    = 8'($urandom);
            ready    = 1'($urandom);
            cycle();
            checks++;
            if (cp_vld !== exp_vld || cp_dout !== exp_dout || bp_thr !== m_thr ||
                bp_hys !== m_hys || ena_rand !== m_ena) begin
                errors++;
                $display("FAIL random[%0d]: vld=%b dout=%h thr=%h hys=%h ena=%b want %b %h %h %h %b",
                         n, cp_vld, cp_dout, bp_thr, bp_hys, ena_rand,
                         exp_vld, exp_dout, m_thr, m_hys, m_ena);
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; grpmt = 8'h00; cp_adr = 10'h0; cp_din = 54'd0;
        ma_padr = 208'd0;
        idle();
        test_reset();
        test_write();
        test_errors();
        test_saturation();
        test_collision();
        test_back_to_back();
        test_reset_midread();
        test_unmapped();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
